// File: rtl/frame_ctrl_pkg.sv
// frame_ctrl_pkg: shared header layout, magic constant and loader state encoding
package frame_ctrl_pkg;
    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_COL_LSB = 16;
    localparam int HDR_FRAME_LSB = 0;
    typedef enum logic [1:0] {IDLE, LOAD, STROBE} state_t;
endpackage

// File: rtl/frame_strobe_decoder.sv
// frame_strobe_decoder: registered one-hot decode of column/frame into a frame strobe pulse
module frame_strobe_decoder #(
    parameter int NumColumns = 4,
    parameter int MaxFramesPerCol = 32
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  i_en,
    input  logic [7:0]                            i_col,
    input  logic [7:0]                            i_frame,
    output logic [NumColumns*MaxFramesPerCol-1:0] o_strobe
);
    logic [NumColumns*MaxFramesPerCol-1:0] w_dec;
    logic [NumColumns*MaxFramesPerCol-1:0] r_strobe;

    // one-hot select of col*MaxFramesPerCol+frame, all zero when disabled
    always_comb begin
        w_dec = '0;
        for (int c = 0; c < NumColumns; c++)
            for (int f = 0; f < MaxFramesPerCol; f++)
                w_dec[c*MaxFramesPerCol+f] = i_en && (i_col == 8'(c)) && (i_frame == 8'(f));
    end

    // register the decode so the strobe is glitch-free and lasts one cycle per enable
    always_ff @(posedge CLK)
        r_strobe <= RST ? '0 : w_dec;

    assign o_strobe = r_strobe;
endmodule

// File: rtl/frame_write_ctrl.sv
// frame_write_ctrl: assembles header + row words into a frame and fires one column frame strobe
module frame_write_ctrl
    import frame_ctrl_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 32,
    parameter int NumRows = 4,
    parameter int NumColumns = 4
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [FrameBitsPerRow-1:0]            in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  err,
    input  logic                                  err_clr,
    output logic [15:0]                           frames_written
);
    localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam logic [8:0] COL_LIM = 9'(NumColumns);
    localparam logic [8:0] FRM_LIM = 9'(MaxFramesPerCol);

    state_t r_state, w_next;
    logic [7:0] r_col, r_frame;
    logic [ROW_W-1:0] r_row;
    logic [NumRows*FrameBitsPerRow-1:0] r_data;
    logic r_err;
    logic [15:0] r_cnt;
    logic w_accept, w_hdr_ok, w_hdr_bad, w_last, w_strobe_en;

    assign in_ready = r_state != STROBE;
    assign busy = r_state != IDLE;
    assign w_accept = in_valid && in_ready;
    assign w_hdr_ok = (in_data[HDR_MAGIC_LSB +: 8] == HDR_MAGIC)
                   && ({1'b0, in_data[HDR_COL_LSB +: 8]} < COL_LIM)
                   && ({1'b0, in_data[HDR_FRAME_LSB +: 8]} < FRM_LIM);
    assign w_hdr_bad = (r_state == IDLE) && w_accept && !w_hdr_ok;
    assign w_last = r_row == ROW_W'(NumRows - 1);
    assign w_strobe_en = (r_state == LOAD) && w_accept && w_last;

    // state register
    always_ff @(posedge CLK)
        r_state <= RST ? IDLE : w_next;

    // next state: header opens a frame, last row hands off to the one-cycle strobe
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_hdr_ok) w_next = LOAD;
            LOAD:    if (w_accept && w_last) w_next = STROBE;
            default: w_next = IDLE;
        endcase
    end

    // header latch, row assembly, sticky error (set beats clear) and completed-frame count
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_col <= '0;
            r_frame <= '0;
            r_row <= '0;
            r_data <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (r_state == IDLE && w_accept && w_hdr_ok) begin
                r_col <= in_data[HDR_COL_LSB +: 8];
                r_frame <= in_data[HDR_FRAME_LSB +: 8];
                r_row <= '0;
            end
            if (r_state == LOAD && w_accept) begin
                r_data[r_row*FrameBitsPerRow +: FrameBitsPerRow] <= in_data;
                r_row <= r_row + 1'b1;
            end
            r_err <= w_hdr_bad || (r_err && !err_clr);
            if (r_state == STROBE) r_cnt <= r_cnt + 16'd1;
        end
    end

    frame_strobe_decoder #(
        .NumColumns(NumColumns),
        .MaxFramesPerCol(MaxFramesPerCol)
    ) u_dec (
        .CLK(CLK),
        .RST(RST),
        .i_en(w_strobe_en),
        .i_col(r_col),
        .i_frame(r_frame),
        .o_strobe(FrameStrobe)
    );

    assign FrameData = r_data;
    assign err = r_err;
    assign frames_written = r_cnt;
endmodule

// File: doc/frame_write_ctrl.md
# frame_write_ctrl

Sequences configuration writes into the fabric's per-tile configuration memories. Accepts a 32-bit word stream (header followed by row data), assembles one frame's data across all tile rows, then pulses exactly one frame-strobe line for one cycle so the addressed column latches it. Sits between the bitstream source (UART/host word stream) and the fabric's FrameData/FrameStrobe distribution.

## Interface

- FrameBitsPerRow, 32: data bits per tile row per frame; equals stream word width.
- MaxFramesPerCol, 32: frames per column; frame index range 0..MaxFramesPerCol-1.
- NumRows, 4: tile rows; data words per frame.
- NumColumns, 4: tile columns; column index range 0..NumColumns-1.

Ports:

- CLK  in  1  sole clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- in_data  in  32  header or data word.
- in_valid  in  1  word present.
- in_ready  out  1  word accepted on cycle where in_valid && in_ready.
- FrameData  out  NumRows*FrameBitsPerRow  row r at bits [r*FrameBitsPerRow +: FrameBitsPerRow].
- FrameStrobe  out  NumColumns*MaxFramesPerCol  one-hot write pulse; bit col*MaxFramesPerCol+frame.
- busy  out  1  high in LOAD and STROBE.
- err  out  1  sticky header error.
- err_clr  in  1  clears err.
- frames_written  out  16  count of completed strobes, wraps at 0xFFFF->0.

## Operation

- Header word: [31:24] magic 8'hA5; [23:16] column; [15:8] reserved (ignored); [7:0] frame index.
- States: IDLE, LOAD, STROBE.
- IDLE: in_ready=1. Accepted header with magic match, column<NumColumns, frame<MaxFramesPerCol -> latch col/frame, row counter=0, go LOAD. Any invalid header is consumed, err set, stay IDLE.
- LOAD: in_ready=1. Each accepted word written to FrameData row[row counter], counter++. Accepting row NumRows-1 -> STROBE. Data words are not checked for magic.
- STROBE: in_ready=0; FrameStrobe bit for latched col/frame high this cycle only; frames_written++; next state IDLE.
- FrameData holds its value outside LOAD writes; stable throughout STROBE and afterwards until overwritten.
- err: set on invalid header; cleared by err_clr; simultaneous set and clear -> set wins.
- Reset values: state IDLE, in_ready=1 (combinational from state), FrameData all 0, FrameStrobe all 0, busy 0, err 0, frames_written 0, counters 0.

## Timing

- Header accepted at edge t; data words accepted no earlier than t+1..t+NumRows; FrameStrobe high in cycle following the last data handshake; back-to-back stream yields one frame every NumRows+2 cycles.
- FrameStrobe is registered: never glitches, never more than one bit high, never high for more than one cycle per frame.
- in_valid low in LOAD stalls indefinitely; partial frame retained, no timeout.
- RST mid-LOAD or in STROBE: next edge returns to IDLE, FrameStrobe 0, FrameData cleared, partial frame discarded, no strobe issued.
- Row counter width $clog2(NumRows) (min 1); index compares use full 8-bit header fields, so out-of-range values never alias.

## Structure

- Shared package frame_ctrl_pkg: header magic constant, header field bit positions, state enum (IDLE/LOAD/STROBE).
- One sub-module frame_strobe_decoder: registered column/frame -> one-hot FrameStrobe decode with enable; reusable by other configuration loaders.

## Test plan

- Header 0xA5010003 then words 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back -> FrameStrobe bit 35 (1*32+3) high exactly one cycle, cycle after 4th word; FrameData = 0x44444444_33333333_22222222_11111111; frames_written=1.
- Header 0x5A000000 -> err=1, no strobe, remains IDLE; next valid frame still completes; err_clr with no new error -> err=0.
- Header column 4 (0xA5040000) and frame 32 (0xA5000020) -> err set, no strobe, no FrameData change.
- Valid header, 2 data words, in_valid low 10 cycles, remaining 2 words -> single strobe after 4th word; in_ready low only in STROBE cycle.
- RST asserted after 3rd data word -> no strobe, FrameData=0, subsequent full frame works normally.
- 65536 frames (or counter preloaded via force to 0xFFFF) -> frames_written wraps to 0; err_clr and invalid header in same cycle -> err stays 1.
